// File: rtl/wb_strb_arbiter_pkg.sv
// Shared types and helpers for the two-master pulsed-strobe Wishbone arbiter.
package wb_strb_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBus  = 1'b1
  } arb_state_e;

  // Round-robin pick: on a tie the master that was not granted last wins.
  function automatic logic pick_grant(input logic [1:0] pending, input logic last_grant);
    if (pending == 2'b11) begin
      return ~last_grant;
    end
    return pending[1];
  endfunction

endpackage

// File: rtl/wb_req_slot.sv
// One-deep request capture for a pulsed-strobe master, with sticky overrun flag.
module wb_req_slot #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cyc_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   sel_i,
  input  logic [ADDR_W-1:0]     adr_i,
  input  logic [DATA_W-1:0]     dat_i,
  input  logic                  retire_i,
  output logic                  pending_o,
  output logic                  we_o,
  output logic [DATA_W/8-1:0]   sel_o,
  output logic [ADDR_W-1:0]     adr_o,
  output logic [DATA_W-1:0]     dat_o,
  output logic                  ovf_o
);

  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                we_q;
  logic [DATA_W/8-1:0] sel_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic                accept;

  // A slot retiring this edge frees room for a strobe arriving on the same edge.
  assign accept = cyc_i && (!pend_q || retire_i);

  always_comb begin
    pend_d = pend_q;
    if (retire_i) pend_d = 1'b0;
    if (accept)   pend_d = 1'b1;
    ovf_d = ovf_q | (cyc_i & ~accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (accept) begin
        we_q  <= we_i;
        sel_q <= sel_i;
        adr_q <= adr_i;
        dat_q <= dat_i;
      end
    end
  end

  assign pending_o = pend_q;
  assign ovf_o     = ovf_q;
  assign we_o      = we_q;
  assign sel_o     = sel_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;

endmodule

// File: rtl/wb_strb_arbiter.sv
// Two-master round-robin arbiter turning one-cycle request pulses into held Wishbone cycles.
module wb_strb_arbiter
  import wb_strb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_cyc_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_cyc_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  output logic [1:0]          ovf_o,
  output logic                busy_o
);

  localparam int unsigned SelW = DATA_W / 8;
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  logic [1:0]        pend, retire, slot_we, slot_ovf;
  logic [SelW-1:0]   slot_sel [2];
  logic [ADDR_W-1:0] slot_adr [2];
  logic [DATA_W-1:0] slot_dat [2];

  wb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk      (clk),
    .reset    (reset),
    .cyc_i    (m0_cyc_i),
    .we_i     (m0_we_i),
    .sel_i    (m0_sel_i),
    .adr_i    (m0_adr_i),
    .dat_i    (m0_dat_i),
    .retire_i (retire[0]),
    .pending_o(pend[0]),
    .we_o     (slot_we[0]),
    .sel_o    (slot_sel[0]),
    .adr_o    (slot_adr[0]),
    .dat_o    (slot_dat[0]),
    .ovf_o    (slot_ovf[0])
  );

  wb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk      (clk),
    .reset    (reset),
    .cyc_i    (m1_cyc_i),
    .we_i     (m1_we_i),
    .sel_i    (m1_sel_i),
    .adr_i    (m1_adr_i),
    .dat_i    (m1_dat_i),
    .retire_i (retire[1]),
    .pending_o(pend[1]),
    .we_o     (slot_we[1]),
    .sel_o    (slot_sel[1]),
    .adr_o    (slot_adr[1]),
    .dat_o    (slot_dat[1]),
    .ovf_o    (slot_ovf[1])
  );

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;  // also the active grant while in StBus
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              s_cyc_q, s_cyc_d, s_we_q, s_we_d;
  logic [SelW-1:0]   s_sel_q, s_sel_d;
  logic [ADDR_W-1:0] s_adr_q, s_adr_d;
  logic [DATA_W-1:0] s_dat_q, s_dat_d;
  logic [1:0]        ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0] rdat_q [2];
  logic [DATA_W-1:0] rdat_d [2];
  logic              gnt;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_cyc_d   = s_cyc_q;
    s_we_d    = s_we_q;
    s_sel_d   = s_sel_q;
    s_adr_d   = s_adr_q;
    s_dat_d   = s_dat_q;
    ack_d     = '0;
    err_d     = '0;
    rdat_d[0] = rdat_q[0];
    rdat_d[1] = rdat_q[1];
    retire    = '0;
    gnt       = pick_grant(pend, last_q);
    unique case (state_q)
      StIdle: begin
        if (|pend) begin
          last_d  = gnt;
          s_cyc_d = 1'b1;
          s_we_d  = slot_we[gnt];
          s_sel_d = slot_sel[gnt];
          s_adr_d = slot_adr[gnt];
          s_dat_d = slot_dat[gnt];
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // err outranks a simultaneous ack and leaves the read data untouched
        if (s_err_i) begin
          s_cyc_d        = 1'b0;
          err_d[last_q]  = 1'b1;
          retire[last_q] = 1'b1;
          state_d        = StIdle;
        end else if (s_ack_i) begin
          s_cyc_d        = 1'b0;
          ack_d[last_q]  = 1'b1;
          rdat_d[last_q] = s_dat_i;
          retire[last_q] = 1'b1;
          state_d        = StIdle;
        end else if (TIMEOUT != 0 && cnt_q == ToLast) begin
          s_cyc_d        = 1'b0;
          err_d[last_q]  = 1'b1;
          retire[last_q] = 1'b1;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      s_cyc_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_sel_q   <= '0;
      s_adr_q   <= '0;
      s_dat_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdat_q[0] <= '0;
      rdat_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      s_cyc_q   <= s_cyc_d;
      s_we_q    <= s_we_d;
      s_sel_q   <= s_sel_d;
      s_adr_q   <= s_adr_d;
      s_dat_q   <= s_dat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdat_q[0] <= rdat_d[0];
      rdat_q[1] <= rdat_d[1];
    end
  end

  assign s_cyc_o  = s_cyc_q;
  assign s_stb_o  = s_cyc_q;
  assign s_we_o   = s_we_q;
  assign s_sel_o  = s_sel_q;
  assign s_adr_o  = s_adr_q;
  assign s_dat_o  = s_dat_q;
  assign m0_ack_o = ack_q[0];
  assign m1_ack_o = ack_q[1];
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];
  assign m0_dat_o = rdat_q[0];
  assign m1_dat_o = rdat_q[1];
  assign ovf_o    = slot_ovf;
  assign busy_o   = (state_q == StBus) || (|pend);

endmodule

// File: tb/tb_wb_strb_arbiter.sv
// Scoreboard bench for wb_strb_arbiter: responses expected per request, popped as acks/errs appear.
module tb_wb_strb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc_i, m0_we_i, m1_cyc_i, m1_we_i;
  logic [1:0]  m0_sel_i, m1_sel_i, s_sel_o, ovf_o;
  logic [31:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [15:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, busy_o;

  wb_strb_arbiter #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .ovf_o(ovf_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        m;
    logic        is_err;
    logic [15:0] dat;
  } resp_t;

  resp_t       sb_q[$];
  resp_t       mon_got, mon_exp;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mdl_dat [2];
  int          slv_mode = 0;  // 0 ack, 1 never respond, 2 ack+err together
  int          slv_delay = 3;
  int          slv_cnt = 0;
  int          hi_run = 0, lo_run = 0, cyc_len_last = 0, gap_last = 0;
  bit          seen_fall = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: responds in the (slv_delay+1)-th cycle of each cycle; read data mirrors the address.
  initial begin
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      if (s_cyc_o && !reset) begin
        slv_cnt++;
        if (slv_mode != 1 && slv_cnt == slv_delay + 1) begin
          s_ack_i = 1'b1;
          s_err_i = (slv_mode == 2);
          s_dat_i = s_we_o ? 16'h0A0A : s_adr_o[15:0];
        end
      end else begin
        slv_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (m0_ack_o | m0_err_o | m1_ack_o | m1_err_o) begin
        check_eq("one_master", (m0_ack_o | m0_err_o) & (m1_ack_o | m1_err_o), 0);
        mon_got.m      = m1_ack_o | m1_err_o;
        mon_got.is_err = mon_got.m ? m1_err_o : m0_err_o;
        mon_got.dat    = mon_got.m ? m1_dat_o : m0_dat_o;
        check_eq("resp_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_exp = sb_q.pop_front();
          check_eq("resp", mon_got, mon_exp);
        end
      end
    end
    if (s_cyc_o) begin
      if (hi_run == 0 && seen_fall) gap_last = lo_run;
      hi_run++;
    end else begin
      if (hi_run > 0) begin
        cyc_len_last = hi_run;
        hi_run = 0;
        lo_run = 0;
        seen_fall = 1;
      end
      lo_run++;
    end
  end

  task automatic expect_resp(input int m, input logic is_err, input logic we, input logic [31:0] adr);
    resp_t r;
    r.m      = (m == 1);
    r.is_err = is_err;
    if (!is_err) mdl_dat[m] = we ? 16'h0A0A : adr[15:0];
    r.dat    = mdl_dat[m];
    sb_q.push_back(r);
  endtask

  task automatic set_req(input int m, input logic we, input logic [31:0] adr, input logic [15:0] dat);
    if (m == 0) begin
      m0_cyc_i = 1'b1; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = 2'b11;
    end else begin
      m1_cyc_i = 1'b1; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = 2'b11;
    end
  endtask

  task automatic pulse();
    @(posedge clk); #1;
    m0_cyc_i = 1'b0;
    m1_cyc_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || busy_o) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_in_budget", n < budget, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_dat[0] = '0;
    mdl_dat[1] = '0;
  endtask

  initial begin
    bit saw_high;
    reset = 1'b1;
    m0_cyc_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    mdl_dat[0] = '0;
    mdl_dat[1] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_cyc", s_cyc_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_ovf", ovf_o, 0);
    check_eq("rst_dat", {m0_dat_o, m1_dat_o}, 0);

    // m0 write, ack after 3 cycles
    expect_resp(0, 1'b0, 1'b1, 32'h10);
    set_req(0, 1'b1, 32'h0000_0010, 16'hBEEF);
    pulse();
    check_eq("wr_t1_cyc", s_cyc_o, 0);
    check_eq("wr_t1_busy", busy_o, 1);
    @(posedge clk); #1;
    check_eq("wr_t2_cyc", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    check_eq("wr_adr", s_adr_o, 32'h10);
    check_eq("wr_dat", s_dat_o, 16'hBEEF);
    check_eq("wr_sel", s_sel_o, 2'b11);
    wait_done(100);
    check_eq("wr_cyc_len", cyc_len_last, 4);

    // simultaneous reads after reset: m0 first, one idle cycle, then m1
    do_reset();
    expect_resp(0, 1'b0, 1'b0, 32'h1234);
    expect_resp(1, 1'b0, 1'b0, 32'h5678);
    set_req(0, 1'b0, 32'h0000_1234, 16'h0);
    set_req(1, 1'b0, 32'h0000_5678, 16'h0);
    pulse();
    @(posedge clk); #1;
    check_eq("tie_first_adr", s_adr_o, 32'h1234);
    wait_done(100);
    check_eq("tie_gap", gap_last, 1);
    check_eq("tie_dat", {m0_dat_o, m1_dat_o}, {16'h1234, 16'h5678});

    // m1 read with silent slave -> timeout err
    slv_mode = 1;
    expect_resp(1, 1'b1, 1'b0, 32'h40);
    set_req(1, 1'b0, 32'h40, 16'h0);
    pulse();
    wait_done(100);
    check_eq("to_cyc_len", cyc_len_last, 16);
    check_eq("to_busy", busy_o, 0);

    // m0 double strobe while pending -> second dropped
    slv_mode = 0;
    expect_resp(0, 1'b0, 1'b1, 32'h20);
    set_req(0, 1'b1, 32'h20, 16'h1111);
    pulse();
    set_req(0, 1'b1, 32'h30, 16'h2222);
    pulse();
    wait_done(100);
    check_eq("ovf_set", ovf_o, 2'b01);
    check_eq("ovf_adr_kept", s_adr_o, 32'h20);

    // ack and err together on m1 read -> err only, data unchanged
    slv_mode = 2;
    expect_resp(1, 1'b1, 1'b0, 32'hDEAD);
    set_req(1, 1'b0, 32'h0000_DEAD, 16'h0);
    pulse();
    wait_done(100);
    check_eq("ackerr_dat", m1_dat_o, 16'h5678);
    check_eq("ovf_sticky", ovf_o, 2'b01);

    // reset while m0 on the bus and m1 pending
    slv_mode = 1;
    set_req(0, 1'b0, 32'h0000_0A00, 16'h0);
    set_req(1, 1'b0, 32'h0000_0B00, 16'h0);
    pulse();
    @(posedge clk); #1;
    check_eq("mid_cyc_up", {s_cyc_o, s_adr_o}, {1'b1, 32'h0A00});
    do_reset();
    check_eq("mid_cyc_drop", s_cyc_o, 0);
    check_eq("mid_ovf", ovf_o, 0);
    check_eq("mid_busy", busy_o, 0);
    saw_high = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (s_cyc_o) saw_high = 1;
    end
    check_eq("mid_no_restart", saw_high, 0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
